// File: rtl/dvp_camera_emulator.sv
// Synthetic OV7670-style DVP source: PCLK at clk/2, VSYNC/HREF framing and
// RGB565 test patterns sent high byte first, for looping into camera_read.
module dvp_camera_emulator #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 288,
    parameter int V_ACTIVE = 480,
    parameter int VS_LINES = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] mode,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] data,
    output logic [7:0] frame_count,
    output logic       busy
);

    localparam int LB        = 2 * H_ACTIVE + H_BLANK;
    localparam int FL        = VS_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW        = $clog2(LB);
    localparam int VW        = $clog2(FL);
    localparam int V_FIRST   = VS_LINES + V_BACK;
    localparam int V_LAST    = V_FIRST + V_ACTIVE;
    localparam int BAR_BYTES = H_ACTIVE / 4;
    localparam int BW        = (BAR_BYTES > 1) ? $clog2(BAR_BYTES) : 1;

    typedef enum logic {S_IDLE, S_FRAME} state_e;

    state_e          state_q, state_d;
    logic            pclk_q;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [VW-1:0]   vcnt_q, vcnt_d;
    logic [1:0]      mode_q, mode_d;
    logic [7:0]      fbase_q, fbase_d;
    logic [7:0]      fc_q, fc_d;
    logic [2:0]      bar_q, bar_d;
    logic [BW-1:0]   sub_q, sub_d;
    logic            vsync_q, vsync_d;
    logic            href_q, href_d;
    logic [7:0]      data_q, data_d;

    logic            adv;
    logic            start;
    logic            in_frame;
    logic            active;
    logic            href_n;
    logic [15:0]     x, y, pix;

    // The edge on which pclk falls is the only edge that moves the raster.
    assign adv = pclk_q;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        mode_d  = mode_q;
        fbase_d = fbase_q;
        fc_d    = fc_q;
        bar_d   = bar_q;
        sub_d   = sub_q;
        vsync_d = vsync_q;
        href_d  = href_q;
        data_d  = data_q;
        start   = 1'b0;

        if (adv) begin
            case (state_q)
                S_IDLE: start = en;
                S_FRAME: begin
                    if (hcnt_q == HW'(LB - 1)) begin
                        hcnt_d = '0;
                        if (vcnt_q == VW'(FL - 1)) begin
                            fc_d = fc_q + 8'd1;
                            if (en) start = 1'b1;
                            else    state_d = S_IDLE;
                        end else begin
                            vcnt_d = vcnt_q + VW'(1);
                        end
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (start) begin
            state_d = S_FRAME;
            hcnt_d  = '0;
            vcnt_d  = '0;
            mode_d  = mode;
            fbase_d = fc_d;
        end

        // Bar index tracks hcnt incrementally: one bar every BAR_BYTES bytes.
        if (hcnt_d == '0) begin
            bar_d = '0;
            sub_d = '0;
        end else if (adv) begin
            if (sub_q == BW'(BAR_BYTES - 1)) begin
                sub_d = '0;
                bar_d = bar_q + 3'd1;
            end else begin
                sub_d = sub_q + BW'(1);
            end
        end

        in_frame = (state_d == S_FRAME);
        active   = in_frame && (vcnt_d >= VW'(V_FIRST)) && (vcnt_d < VW'(V_LAST));
        href_n   = active && (hcnt_d < HW'(2 * H_ACTIVE));
        x        = 16'(hcnt_d >> 1);
        y        = 16'(vcnt_d) - 16'(V_FIRST);

        case (mode_d)
            2'd0:    pix = bar_colour(bar_d);
            2'd1:    pix = {x[7:3], x[7:2], x[7:3]};
            2'd2:    pix = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
            default: pix = x + y + {fbase_d, 8'h00};
        endcase

        if (adv) begin
            vsync_d = in_frame && (vcnt_d < VW'(VS_LINES));
            href_d  = href_n;
            data_d  = !href_n ? 8'h00 : (hcnt_d[0] ? pix[7:0] : pix[15:8]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pclk_q  <= 1'b0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            mode_q  <= '0;
            fbase_q <= '0;
            fc_q    <= '0;
            bar_q   <= '0;
            sub_q   <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            pclk_q  <= ~pclk_q;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            mode_q  <= mode_d;
            fbase_q <= fbase_d;
            fc_q    <= fc_d;
            bar_q   <= bar_d;
            sub_q   <= sub_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
        end
    end

    assign pclk        = pclk_q;
    assign vsync       = vsync_q;
    assign href        = href_q;
    assign data        = data_q;
    assign frame_count = fc_q;
    assign busy        = (state_q == S_FRAME);

endmodule

// File: tb/tb_dvp_camera_emulator.sv
// Directed bench for dvp_camera_emulator on a small 16x4 raster (LB=36, FL=7).
module tb_dvp_camera_emulator;

    localparam int HA  = 16;
    localparam int HB  = 4;
    localparam int VA  = 4;
    localparam int VSL = 1;
    localparam int VB  = 1;
    localparam int VF  = 1;
    localparam int LB  = 2 * HA + HB;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic       pclk, vsync, href, busy;
    logic [7:0] data, frame_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int cur_h, cur_v;
    int vs_cnt, href_cnt, rises, first_rise;
    logic       href_prev;
    logic [7:0] hi_byte;
    logic [7:0] line_buf [LB];
    logic [7:0] exp_line [LB];

    dvp_camera_emulator #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
        .VS_LINES(VSL), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .pclk(pclk), .vsync(vsync), .href(href), .data(data),
        .frame_count(frame_count), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h (h=%0d v=%0d)", tag, obs, exp, cur_h, cur_v);
        end
    endtask

    function automatic logic [15:0] exp_pix(input int m, input int x, input int y, input int fc);
        logic [15:0] xv, yv;
        xv = 16'(x);
        yv = 16'(y);
        case (m)
            0: case (x / (HA / 8))
                   0: return 16'hFFFF;
                   1: return 16'hFFE0;
                   2: return 16'h07FF;
                   3: return 16'h07E0;
                   4: return 16'hF81F;
                   5: return 16'hF800;
                   6: return 16'h001F;
                   default: return 16'h0000;
               endcase
            1: return {xv[7:3], xv[7:2], xv[7:3]};
            2: return (xv[3] ^ yv[3]) ? 16'hFFFF : 16'h0000;
            default: return 16'(x + y + fc * 256);
        endcase
    endfunction

    task automatic step();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(posedge clk);
            #1;
            found = (pclk === 1'b0);
        end
        chk("advance_seen", 16'(found), 16'd1);
    endtask

    task automatic check_pos(input int m, input int fc);
        logic vs_e, hr_e;
        logic [15:0] pix;
        logic [7:0] d_e;
        vs_e = (cur_v < VSL);
        hr_e = (cur_v >= VSL + VB) && (cur_v < VSL + VB + VA) && (cur_h < 2 * HA);
        pix  = exp_pix(m, cur_h / 2, cur_v - (VSL + VB), fc);
        d_e  = !hr_e ? 8'h00 : ((cur_h % 2 == 0) ? pix[15:8] : pix[7:0]);
        chk("vsync", 16'(vsync), 16'(vs_e));
        chk("href", 16'(href), 16'(hr_e));
        chk("data", 16'(data), 16'(d_e));
        chk("busy", 16'(busy), 16'd1);
        chk("frame_count", 16'(frame_count), 16'(fc));
        if (hr_e && (cur_h % 2 == 1)) chk("pixel16", {hi_byte, data}, pix);
        if (cur_h % 2 == 0) hi_byte = data;
        if (cur_v == VSL + VB) line_buf[cur_h] = data;
        if (vsync === 1'b1) vs_cnt++;
        if (href === 1'b1) begin
            href_cnt++;
            if (href_prev !== 1'b1) begin
                if (rises == 0) first_rise = cur_v * LB + cur_h;
                rises++;
            end
        end
        href_prev = href;
    endtask

    task automatic run_to(input int m, input int fc, input int ve, input int he);
        while (!(cur_v == ve && cur_h == he)) begin
            step();
            cur_h++;
            if (cur_h == LB) begin
                cur_h = 0;
                cur_v++;
            end
            check_pos(m, fc);
        end
    endtask

    task automatic new_frame(input int m, input int fc);
        step();
        cur_h = 0;
        cur_v = 0;
        href_prev = 1'b0;
        check_pos(m, fc);
    endtask

    task automatic check_idle(input int fc);
        chk("idle_vsync", 16'(vsync), 16'd0);
        chk("idle_href", 16'(href), 16'd0);
        chk("idle_data", 16'(data), 16'd0);
        chk("idle_busy", 16'(busy), 16'd0);
        chk("idle_fc", 16'(frame_count), 16'(fc));
    endtask

    task automatic check_zero();
        chk("rst_pclk", 16'(pclk), 16'd0);
        chk("rst_vsync", 16'(vsync), 16'd0);
        chk("rst_href", 16'(href), 16'd0);
        chk("rst_data", 16'(data), 16'd0);
        chk("rst_fc", 16'(frame_count), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
    endtask

    initial begin
        exp_line = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'hFF, 8'hE0,
                     8'h07, 8'hFF, 8'h07, 8'hFF, 8'h07, 8'hE0, 8'h07, 8'hE0,
                     8'hF8, 8'h1F, 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'hF8, 8'h00,
                     8'h00, 8'h1F, 8'h00, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00};
        cur_h = 0; cur_v = 0; hi_byte = 8'h00; href_prev = 1'b0;
        vs_cnt = 0; href_cnt = 0; rises = 0; first_rise = -1;
        reset = 1'b1; en = 1'b1; mode = 2'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero();
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        chk("pclk_first_rise", 16'(pclk), 16'd1);
        chk("no_vsync_before_adv", 16'(vsync), 16'd0);
        chk("no_busy_before_adv", 16'(busy), 16'd0);

        // Frame A: colour bars; mode switched to 1 mid-frame has no effect
        new_frame(0, 0);
        @(posedge clk);
        #1;
        chk("pclk_high_half", 16'(pclk), 16'd1);
        chk("vsync_held", 16'(vsync), 16'd1);
        cur_h = 0;
        run_to(0, 0, 3, 0);
        mode = 2'd1;
        run_to(0, 0, 6, 35);
        chk("vsync_len", 16'(vs_cnt), 16'd36);
        chk("href_total", 16'(href_cnt), 16'd128);
        chk("href_pulses", 16'(rises), 16'd4);
        chk("href_first_rise", 16'(first_rise), 16'd72);
        for (int i = 0; i < LB; i++) chk("bars_line0", 16'(line_buf[i]), 16'(exp_line[i]));

        // Frame B: grey ramp, frame_count=1 after the first wrap
        new_frame(1, 1);
        run_to(1, 1, 3, 0);
        mode = 2'd2;
        run_to(1, 1, 6, 35);
        chk("ramp_x8_hi", 16'(line_buf[16]), 16'h08);
        chk("ramp_x8_lo", 16'(line_buf[17]), 16'h41);
        chk("ramp_x15_lo", 16'(line_buf[31]), 16'h61);

        // Frame C: checkerboard, en dropped at vcnt=3 so the frame ends in IDLE
        new_frame(2, 2);
        run_to(2, 2, 3, 0);
        en = 1'b0;
        mode = 2'd3;
        run_to(2, 2, 6, 35);
        chk("check_x7_hi", 16'(line_buf[14]), 16'h00);
        chk("check_x8_hi", 16'(line_buf[16]), 16'hFF);
        chk("check_x8_lo", 16'(line_buf[17]), 16'hFF);
        step();
        check_idle(3);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("idle_pclk_hi", 16'(pclk), 16'd1);
            step();
            check_idle(3);
        end

        // Frames D, E: diagonal pattern, reassembled 16-bit pixels checked
        en = 1'b1;
        new_frame(3, 3);
        run_to(3, 3, 6, 35);
        new_frame(3, 4);
        run_to(3, 4, 2, 10);
        chk("href_before_reset", 16'(href), 16'd1);

        // Asynchronous reset in the middle of an active line
        #2 reset = 1'b1;
        #1;
        check_zero();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_pclk", 16'(pclk), 16'd0);
        chk("rst_hold_busy", 16'(busy), 16'd0);
        @(negedge clk) reset = 1'b0;
        new_frame(3, 0);
        run_to(3, 0, 6, 35);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
